// File: rtl/ctrl_seq_pkg.sv
// Shared constants for the top-level control sequencer: state codes, LED codes.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package ctrl_seq_pkg;

    // State codes, visible on controlstate
    localparam logic [3:0] ST_RST    = 4'd0;
    localparam logic [3:0] ST_INIT   = 4'd1;
    localparam logic [3:0] ST_CFG    = 4'd2;
    localparam logic [3:0] ST_PROG   = 4'd3;
    localparam logic [3:0] ST_READ   = 4'd4;
    localparam logic [3:0] ST_LOAD   = 4'd5;
    localparam logic [3:0] ST_IDLE   = 4'd6;
    localparam logic [3:0] ST_ACTIVE = 4'd7;
    localparam logic [3:0] ST_FAULT  = 4'd8;

    // Programming LED modes
    localparam logic [1:0] LED_OFF   = 2'b00;
    localparam logic [1:0] LED_BLINK = 2'b01;
    localparam logic [1:0] LED_ON    = 2'b10;
    localparam logic [1:0] LED_FAULT = 2'b11;

    // Largest supported channel count
    localparam int unsigned N_CH_MAX = 8;

    // LED mode for a given state. The LED stays solid from READ onward because
    // a successful UFM write is what moves PROG to READ.
    function automatic logic [1:0] led_for_state(input logic [3:0] st);
        logic [1:0] led;
        case (st)
            ST_PROG:                              led = LED_BLINK;
            ST_READ, ST_LOAD, ST_IDLE, ST_ACTIVE: led = LED_ON;
            ST_FAULT:                             led = LED_FAULT;
            default:                              led = LED_OFF;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/ctrl_seq_ch_stagger.sv
// One sequenced output channel: enable latches once the previous stage has aged.
// Latency: enable registered, 1 cycle after prev_aged && ready && go.
// Backpressure: none; ready gates the set, an enable never drops while active.
//
// Ports: clk, reset (async, active-high); active = sequencer will be in ACTIVE
// next cycle (low clears everything); go = sequencing allowed this cycle;
// prev_aged = previous stage has been enabled long enough; ready = downstream
// ready; en = channel enable; aged = this channel has been enabled STAGGER
// cycles, feeding the next channel.
module ctrl_seq_ch_stagger #(
    parameter int unsigned STAGGER = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic go,
    input  logic prev_aged,
    input  logic ready,
    output logic en,
    output logic aged
);

    localparam int unsigned   CW      = $clog2(STAGGER + 1);
    localparam logic [CW-1:0] AGE_MAX = CW'(STAGGER - 1);

    logic [CW-1:0] age_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en      <= 1'b0;
            age_cnt <= '0;
        end else if (!active) begin
            en      <= 1'b0;
            age_cnt <= '0;
        end else begin
            if (go && prev_aged && ready)
                en <= 1'b1;
            // age_cnt is 0 in the first enabled cycle, so reaching STAGGER-1
            // means the next channel's enable lands STAGGER cycles after ours.
            if (en && (age_cnt != AGE_MAX))
                age_cnt <= age_cnt + 1'b1;
        end
    end

    assign aged = en && (age_cnt == AGE_MAX);

endmodule

// File: rtl/ctrl_seq.sv
// Top-level power-up/control sequencer with per-wait timeout and staggered channel enables.
// Latency: all outputs registered, 1 cycle from input event to output change.
// Backpressure: none; waits on done flags, optional timeout (CTRL_TIMEOUT_EN) escapes to FAULT.
//
// Ports: clk, reset (async, active-high); sw_res/sw_ena debounced switch levels
// with *_rise one-cycle edge pulses; init/cfg/write/read/load_done sub-block done
// flags; arm_ok clock generator idle; ch_ready per-channel ready.
// Outputs: controlstate (state code), sub_reset, ch_en, prog_led, fault, fault_code.
// Macro CTRL_TIMEOUT_EN: when defined, wait states time out after 2^TO_W-1
// waiting cycles into FAULT; otherwise fault and fault_code are tied to 0.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned RESET_HOLD = 3,
    parameter int unsigned STAGGER    = 16,
    parameter int unsigned TO_W       = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sw_res,
    input  logic            sw_res_rise,
    input  logic            sw_ena,
    input  logic            sw_ena_rise,
    input  logic            init_done,
    input  logic            cfg_done,
    input  logic            write_done,
    input  logic            read_done,
    input  logic            load_done,
    input  logic            arm_ok,
    input  logic [N_CH-1:0] ch_ready,
    output logic [3:0]      controlstate,
    output logic            sub_reset,
    output logic [N_CH-1:0] ch_en,
    output logic [1:0]      prog_led,
    output logic            fault,
    output logic [3:0]      fault_code
);

    localparam int unsigned       HOLD_W   = $clog2(RESET_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RESET_HOLD);
    localparam int unsigned       STG_W    = $clog2(STAGGER + 1);
    localparam logic [STG_W-1:0]  STG_MAX  = STG_W'(STAGGER - 1);

    logic [3:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              init_seen_q, init_seen_d;
    logic              hold_ok, init_ok, timeout;
    logic [STG_W-1:0]  entry_cnt_q;
    logic              go, ch_active;
    logic [N_CH:0]     aged_chain;
    logic              sub_reset_d;
    logic [1:0]        prog_led_d;

    assign hold_ok = (hold_q == HOLD_MAX);
    // init_done may pulse while sub_reset is still held; remember it.
    assign init_ok = hold_ok && (init_done || init_seen_q);

    // ------------------------------------------------------------------
    // Timeout
    // ------------------------------------------------------------------
`ifdef CTRL_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = ~TO_W'(1);  // one below all-ones

    logic [TO_W-1:0] to_cnt_q;
    logic            waiting;
    logic [3:0]      fault_code_q;
    logic            fault_q;

    // Waiting means the state's own done condition is false; LOAD's switch
    // qualifiers are operator action, not a stalled sub-block.
    always_comb begin
        case (state_q)
            ST_INIT: waiting = !init_ok;
            ST_CFG:  waiting = !cfg_done;
            ST_PROG: waiting = !write_done;
            ST_READ: waiting = !read_done;
            ST_LOAD: waiting = !load_done;
            default: waiting = 1'b0;
        endcase
    end

    // Fires on the waiting cycle that would take the counter to all-ones.
    assign timeout = waiting && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q     <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= 4'd0;
        end else begin
            if (state_d != state_q)
                to_cnt_q <= '0;
            else if (waiting)
                to_cnt_q <= to_cnt_q + 1'b1;
            fault_q <= (state_d == ST_FAULT);
            if (state_d != ST_FAULT)
                fault_code_q <= 4'd0;
            else if (state_q != ST_FAULT)
                fault_code_q <= state_q;
        end
    end

    assign fault      = fault_q;
    assign fault_code = fault_code_q;
`else
    assign timeout    = 1'b0;
    assign fault      = 1'b0;
    assign fault_code = 4'd0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register (with registered outputs and counters)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RST;
            hold_q      <= '0;
            init_seen_q <= 1'b0;
            entry_cnt_q <= '0;
            sub_reset   <= 1'b0;
            prog_led    <= LED_OFF;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            init_seen_q <= init_seen_d;
            if (state_q != ST_ACTIVE)
                entry_cnt_q <= '0;
            else if (entry_cnt_q != STG_MAX)
                entry_cnt_q <= entry_cnt_q + 1'b1;
            sub_reset   <= sub_reset_d;
            prog_led    <= prog_led_d;
        end
    end

    assign controlstate = state_q;

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (sw_res_rise) begin
            state_d = ST_RST;
        end else begin
            case (state_q)
                ST_RST:    if (sw_ena_rise && sw_res)             state_d = ST_INIT;
                ST_INIT:   if (init_ok)                           state_d = ST_CFG;
                           else if (timeout)                      state_d = ST_FAULT;
                ST_CFG:    if (cfg_done)                          state_d = ST_PROG;
                           else if (timeout)                      state_d = ST_FAULT;
                ST_PROG:   if (write_done)                        state_d = ST_READ;
                           else if (timeout)                      state_d = ST_FAULT;
                ST_READ:   if (read_done)                         state_d = ST_LOAD;
                           else if (timeout)                      state_d = ST_FAULT;
                ST_LOAD:   if (load_done && !sw_res && !sw_ena)   state_d = ST_IDLE;
                           else if (timeout)                      state_d = ST_FAULT;
                ST_IDLE:   if (arm_ok && !sw_res && sw_ena_rise)  state_d = ST_ACTIVE;
                ST_ACTIVE: if (!sw_ena && !sw_res)                state_d = ST_READ;
                ST_FAULT:                                         state_d = ST_FAULT;
                default:                                          state_d = ST_RST;
            endcase
        end
    end

    // Hold counter and early-init latch only live while staying in INIT.
    always_comb begin
        hold_d      = '0;
        init_seen_d = 1'b0;
        if ((state_q == ST_INIT) && (state_d == ST_INIT)) begin
            hold_d      = hold_ok ? hold_q : hold_q + 1'b1;
            init_seen_d = init_seen_q || init_done;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (computed from next state, so they switch with the state)
    // ------------------------------------------------------------------
    always_comb begin
        sub_reset_d = ((state_d == ST_INIT) && (hold_d != HOLD_MAX)) ||
                      (state_d == ST_FAULT);
        prog_led_d  = led_for_state(state_d);
    end

    // ------------------------------------------------------------------
    // Channel stagger chain
    // ------------------------------------------------------------------
    // sw_res level freezes sequencing; leaving ACTIVE clears all enables via ch_active.
    assign go         = (state_q == ST_ACTIVE) && sw_ena && !sw_res;
    assign ch_active  = (state_d == ST_ACTIVE);
    // Channel 0 ages off the time spent in ACTIVE, as if a virtual channel
    // had been enabled on entry.
    assign aged_chain[0] = (state_q == ST_ACTIVE) && (entry_cnt_q == STG_MAX);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        ctrl_seq_ch_stagger #(
            .STAGGER (STAGGER)
        ) u_ch_stagger (
            .clk       (clk),
            .reset     (reset),
            .active    (ch_active),
            .go        (go),
            .prev_aged (aged_chain[k]),
            .ready     (ch_ready[k]),
            .en        (ch_en[k]),
            .aged      (aged_chain[k+1])
        );
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: reset, bring-up flow, stagger, exit, priority, timeout.
// Latency: inputs driven #1 after posedge, outputs sampled #1 after posedge.
// Backpressure: n/a.
module tb_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw_res, sw_res_rise, sw_ena, sw_ena_rise;
    logic       init_done, cfg_done, write_done, read_done, load_done, arm_ok;
    logic [1:0] ch_ready;
    logic [3:0] controlstate;
    logic       sub_reset;
    logic [1:0] ch_en;
    logic [1:0] prog_led;
    logic       fault;
    logic [3:0] fault_code;

    int checks = 0;
    int errors = 0;

    ctrl_seq #(
        .N_CH       (2),
        .RESET_HOLD (3),
        .STAGGER    (16),
        .TO_W       (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_res       (sw_res),
        .sw_res_rise  (sw_res_rise),
        .sw_ena       (sw_ena),
        .sw_ena_rise  (sw_ena_rise),
        .init_done    (init_done),
        .cfg_done     (cfg_done),
        .write_done   (write_done),
        .read_done    (read_done),
        .load_done    (load_done),
        .arm_ok       (arm_ok),
        .ch_ready     (ch_ready),
        .controlstate (controlstate),
        .sub_reset    (sub_reset),
        .ch_en        (ch_en),
        .prog_led     (prog_led),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    always #20 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RST -> CFG (state 2) with init_done held from the start
    task automatic to_cfg();
        sw_res = 1'b1; sw_ena_rise = 1'b1;
        tick();
        sw_ena_rise = 1'b0; init_done = 1'b1;
        repeat (4) tick();
        init_done = 1'b0;
    endtask

    task automatic to_prog();
        to_cfg();
        cfg_done = 1'b1; tick(); cfg_done = 1'b0;
    endtask

    task automatic to_idle();
        to_prog();
        write_done = 1'b1; tick(); write_done = 1'b0;
        read_done  = 1'b1; tick(); read_done  = 1'b0;
        sw_res = 1'b0; sw_ena = 1'b0;
        load_done  = 1'b1; tick(); load_done  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sw_res = 0; sw_res_rise = 0; sw_ena = 0; sw_ena_rise = 0;
        init_done = 0; cfg_done = 0; write_done = 0; read_done = 0; load_done = 0;
        arm_ok = 0; ch_ready = 2'b00;
        tick(); tick();
        checks++;
        if ({controlstate, ch_en, sub_reset, prog_led, fault, fault_code} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs state=%0d ch_en=%b sub_reset=%b led=%b fault=%b code=%0d required all 0",
                     controlstate, ch_en, sub_reset, prog_led, fault, fault_code);
        end
        reset = 1'b0;
        sw_ena_rise = 1'b1;  // without sw_res this must not start the flow
        tick();
        sw_ena_rise = 1'b0;
        checks++;
        if (controlstate !== 4'd0) begin
            errors++; $display("FAIL rst_needs_sw_res state=%0d required 0", controlstate);
        end
    endtask

    task automatic test_reset_flow();
        sw_res = 1'b1; sw_ena_rise = 1'b1;
        tick();                                   // entry E0
        sw_ena_rise = 1'b0; init_done = 1'b1;     // early, must be remembered
        checks++;
        if (controlstate !== 4'd1 || sub_reset !== 1'b1) begin
            errors++; $display("FAIL init_entry state=%0d sub_reset=%b required 1/1", controlstate, sub_reset);
        end
        tick(); init_done = 1'b0;                 // E1
        checks++;
        if (sub_reset !== 1'b1) begin
            errors++; $display("FAIL sub_reset_e1 got %b required 1", sub_reset);
        end
        tick();                                   // E2
        checks++;
        if (sub_reset !== 1'b1 || controlstate !== 4'd1) begin
            errors++; $display("FAIL sub_reset_e2 got %b state=%0d required 1/1", sub_reset, controlstate);
        end
        tick();                                   // E3
        checks++;
        if (sub_reset !== 1'b0 || controlstate !== 4'd1) begin
            errors++; $display("FAIL sub_reset_e3 got %b state=%0d required 0/1", sub_reset, controlstate);
        end
        tick();                                   // E4
        checks++;
        if (controlstate !== 4'd2 || prog_led !== 2'b00) begin
            errors++; $display("FAIL cfg_entry state=%0d led=%b required 2/00", controlstate, prog_led);
        end
        cfg_done = 1'b1; tick(); cfg_done = 1'b0;
        checks++;
        if (controlstate !== 4'd3 || prog_led !== 2'b01) begin
            errors++; $display("FAIL prog_entry state=%0d led=%b required 3/01", controlstate, prog_led);
        end
    endtask

    task automatic test_prog_load();
        write_done = 1'b1; tick(); write_done = 1'b0;
        checks++;
        if (controlstate !== 4'd4 || prog_led !== 2'b10) begin
            errors++; $display("FAIL read_entry state=%0d led=%b required 4/10", controlstate, prog_led);
        end
        read_done = 1'b1; tick(); read_done = 1'b0;
        load_done = 1'b1;                        // sw_res still high: must wait
        tick();
        checks++;
        if (controlstate !== 4'd5) begin
            errors++; $display("FAIL load_wait_sw state=%0d required 5", controlstate);
        end
        sw_res = 1'b0; tick(); load_done = 1'b0;
        checks++;
        if (controlstate !== 4'd6 || ch_en !== 2'b00 || prog_led !== 2'b10) begin
            errors++; $display("FAIL idle_entry state=%0d ch_en=%b led=%b required 6/00/10", controlstate, ch_en, prog_led);
        end
    endtask

    task automatic test_stagger();
        ch_ready = 2'b11; sw_ena = 1'b1;
        arm_ok = 1'b0; sw_ena_rise = 1'b1; tick(); sw_ena_rise = 1'b0;
        checks++;
        if (controlstate !== 4'd6) begin
            errors++; $display("FAIL rise_without_arm state=%0d required 6", controlstate);
        end
        arm_ok = 1'b1; tick();
        checks++;
        if (controlstate !== 4'd6) begin
            errors++; $display("FAIL rise_not_remembered state=%0d required 6", controlstate);
        end
        sw_ena_rise = 1'b1; tick(); sw_ena_rise = 1'b0;     // E0
        checks++;
        if (controlstate !== 4'd7 || ch_en !== 2'b00) begin
            errors++; $display("FAIL active_entry state=%0d ch_en=%b required 7/00", controlstate, ch_en);
        end
        repeat (15) tick();                                  // E15
        checks++;
        if (ch_en !== 2'b00) begin
            errors++; $display("FAIL stagger_e15 ch_en=%b required 00", ch_en);
        end
        tick();                                              // E16
        checks++;
        if (ch_en !== 2'b01) begin
            errors++; $display("FAIL stagger_e16 ch_en=%b required 01", ch_en);
        end
        repeat (15) tick();                                  // E31
        checks++;
        if (ch_en !== 2'b01) begin
            errors++; $display("FAIL stagger_e31 ch_en=%b required 01", ch_en);
        end
        tick();                                              // E32
        checks++;
        if (ch_en !== 2'b11) begin
            errors++; $display("FAIL stagger_e32 ch_en=%b required 11", ch_en);
        end
        ch_ready = 2'b00; tick();
        checks++;
        if (ch_en !== 2'b11) begin
            errors++; $display("FAIL ready_drop_keeps ch_en=%b required 11", ch_en);
        end
        sw_res = 1'b1; sw_ena = 1'b0; tick();                // frozen: no exit
        checks++;
        if (controlstate !== 4'd7 || ch_en !== 2'b11) begin
            errors++; $display("FAIL freeze state=%0d ch_en=%b required 7/11", controlstate, ch_en);
        end
        sw_res = 1'b0; tick();
        checks++;
        if (controlstate !== 4'd4 || ch_en !== 2'b00) begin
            errors++; $display("FAIL exit state=%0d ch_en=%b required 4/00", controlstate, ch_en);
        end
        read_done = 1'b1; tick(); read_done = 1'b0;
        load_done = 1'b1; tick(); load_done = 1'b0;
        checks++;
        if (controlstate !== 4'd6) begin
            errors++; $display("FAIL back_to_idle state=%0d required 6", controlstate);
        end
    endtask

    task automatic test_stagger_ready();
        ch_ready = 2'b01; sw_ena = 1'b1; arm_ok = 1'b1;
        sw_ena_rise = 1'b1; tick(); sw_ena_rise = 1'b0;     // E0
        for (int i = 1; i <= 39; i++) begin
            tick();
            if (i == 16) begin
                checks++;
                if (ch_en !== 2'b01) begin
                    errors++; $display("FAIL ready_run_e16 ch_en=%b required 01", ch_en);
                end
            end
        end
        checks++;                                            // E39
        if (ch_en !== 2'b01) begin
            errors++; $display("FAIL ready_run_e39 ch_en=%b required 01", ch_en);
        end
        ch_ready = 2'b11; tick();                            // E40
        checks++;
        if (ch_en !== 2'b11) begin
            errors++; $display("FAIL ready_run_e40 ch_en=%b required 11", ch_en);
        end
        sw_ena = 1'b0; tick();
        checks++;
        if (controlstate !== 4'd4 || ch_en !== 2'b00) begin
            errors++; $display("FAIL exit2 state=%0d ch_en=%b required 4/00", controlstate, ch_en);
        end
    endtask

    task automatic test_priority();
        sw_res_rise = 1'b1; tick(); sw_res_rise = 1'b0;
        checks++;
        if (controlstate !== 4'd0 || prog_led !== 2'b00) begin
            errors++; $display("FAIL sw_res_rise_read state=%0d led=%b required 0/00", controlstate, prog_led);
        end
        to_prog();
        write_done = 1'b1; sw_res_rise = 1'b1; tick();
        write_done = 1'b0; sw_res_rise = 1'b0;
        checks++;
        if (controlstate !== 4'd0 || prog_led !== 2'b00) begin
            errors++; $display("FAIL rise_over_done state=%0d led=%b required 0/00", controlstate, prog_led);
        end
    endtask

    task automatic test_timeout();
        to_cfg();                                            // state 2, counter 0
        checks++;
        if (controlstate !== 4'd2) begin
            errors++; $display("FAIL to_cfg state=%0d required 2", controlstate);
        end
        repeat (14) tick();
        checks++;
        if (controlstate !== 4'd2 || fault !== 1'b0) begin
            errors++; $display("FAIL before_timeout state=%0d fault=%b required 2/0", controlstate, fault);
        end
        tick();
`ifdef CTRL_TIMEOUT_EN
        checks++;
        if ({controlstate, fault, fault_code, ch_en, prog_led, sub_reset} !== {4'd8, 1'b1, 4'd2, 2'b00, 2'b11, 1'b1}) begin
            errors++; $display("FAIL timeout_fault state=%0d fault=%b code=%0d ch_en=%b led=%b sub_reset=%b required 8/1/2/00/11/1",
                               controlstate, fault, fault_code, ch_en, prog_led, sub_reset);
        end
        cfg_done = 1'b1; tick(); cfg_done = 1'b0;
        checks++;
        if (controlstate !== 4'd8) begin
            errors++; $display("FAIL fault_sticky state=%0d required 8", controlstate);
        end
`else
        checks++;
        if (controlstate !== 4'd2 || fault !== 1'b0 || fault_code !== 4'd0) begin
            errors++; $display("FAIL no_timeout state=%0d fault=%b code=%0d required 2/0/0", controlstate, fault, fault_code);
        end
`endif
        sw_res_rise = 1'b1; tick(); sw_res_rise = 1'b0;
        checks++;
        if ({controlstate, fault, fault_code, prog_led, sub_reset} !== 12'd0) begin
            errors++; $display("FAIL fault_exit state=%0d fault=%b code=%0d led=%b sub_reset=%b required all 0",
                               controlstate, fault, fault_code, prog_led, sub_reset);
        end
    endtask

    task automatic test_async_reset();
        to_idle();
        ch_ready = 2'b11; arm_ok = 1'b1; sw_ena = 1'b1;
        sw_ena_rise = 1'b1; tick(); sw_ena_rise = 1'b0;      // E0
        repeat (20) tick();                                   // E20
        checks++;
        if (controlstate !== 4'd7 || ch_en !== 2'b01) begin
            errors++; $display("FAIL pre_async state=%0d ch_en=%b required 7/01", controlstate, ch_en);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({controlstate, ch_en, sub_reset, prog_led, fault, fault_code} !== 14'd0) begin
            errors++; $display("FAIL async_reset state=%0d ch_en=%b sub_reset=%b led=%b fault=%b code=%0d required all 0",
                               controlstate, ch_en, sub_reset, prog_led, fault, fault_code);
        end
        reset = 1'b0; sw_ena = 1'b0;
        tick();
        checks++;
        if (controlstate !== 4'd0 || ch_en !== 2'b00) begin
            errors++; $display("FAIL after_async state=%0d ch_en=%b required 0/00", controlstate, ch_en);
        end
    endtask

    initial begin
        test_reset();
        test_reset_flow();
        test_prog_load();
        test_stagger();
        test_stagger_ready();
        test_priority();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Parametrised successor to the hard-coded top-level control FSM.
- Sequences reset → config → UFM program → UFM read → load → idle/active for N_CH output channels (PSU, FG, …).
- Adds per-wait-state timeout with FAULT state and staggered per-channel enables.
- Sits beside the sync/debounce front-end; consumes sub-block done flags; drives channel enables, UFM/sub-block reset and prog-LED mode.

Parameters:
- N_CH, 2, number of sequenced output channels (1..8); ch 0 = PSU, ch 1 = FG.
- RESET_HOLD, 3, cycles sub_reset held high in INIT (≥1).
- STAGGER, 16, cycles between successive channel enables in ACTIVE (≥1).
- TO_W, 20, timeout counter width; timeout = 2^TO_W − 1 cycles.

Ports:
- clk  in  1  system clock (25 MHz domain).
- reset  in  1  asynchronous, active-high.
- sw_res  in  1  debounced reset-switch level.
- sw_res_rise  in  1  one-cycle pulse on sw_res rising edge.
- sw_ena  in  1  debounced enable-switch level.
- sw_ena_rise  in  1  one-cycle pulse on sw_ena rising edge.
- init_done  in  1  pot and clock-gen reset sequences complete.
- cfg_done  in  1  CSR config and pot initial config complete.
- write_done  in  1  UFM write complete.
- read_done  in  1  UFM read-out complete.
- load_done  in  1  reference voltage and frequency/phase loaded.
- arm_ok  in  1  clock generator idle, safe to activate.
- ch_ready  in  N_CH  per-channel downstream ready (e.g. clock running).
- controlstate  out  4  current state code.
- sub_reset  out  1  active-high reset to UFM/ADC sub-blocks.
- ch_en  out  N_CH  channel enables.
- prog_led  out  2  00 off, 01 blink, 10 on, 11 fault-fast.
- fault  out  1  high while in FAULT.
- fault_code  out  4  state code in which the timeout occurred.

Behaviour:
- Async reset: state RST (0); all outputs 0; counters 0.
- sw_res_rise forces RST next cycle from any state. It has the highest priority, including over timeout and any same-cycle transition. ch_en clears in that cycle.
- States and codes:
  - RST(0): prog_led=00, sub_reset=0. → INIT when sw_ena_rise && sw_res.
  - INIT(1): sub_reset=1 for RESET_HOLD cycles, then 0. → CFG when hold elapsed && init_done. init_done arriving early is held until the hold expires.
  - CFG(2): → PROG when cfg_done.
  - PROG(3): prog_led=01. → READ when write_done; prog_led=10 from that transition onward.
  - READ(4): → LOAD when read_done.
  - LOAD(5): → IDLE when load_done && !sw_res && !sw_ena.
  - IDLE(6): ch_en=0. → ACTIVE when arm_ok && !sw_res && sw_ena_rise.
  - ACTIVE(7): see channel sequencing below.
  - FAULT(8): ch_en=0, sub_reset=1, prog_led=11, fault=1. Exit only via sw_res_rise.
- Channel sequencing in ACTIVE:
  - A stagger counter starts at 0 on entry.
  - ch_en[k] sets at the first cycle where all hold: ch_en[k−1] has been high ≥ STAGGER cycles (k=0: STAGGER cycles after entry), ch_ready[k]=1, sw_ena=1, sw_res=0.
  - Once set, ch_en[k] stays high while in ACTIVE; ch_ready[k] falling does not clear it.
  - Exit to READ when !sw_ena && !sw_res. All ch_en clear in the exit cycle.
  - sw_res level high freezes sequencing: no new enables, no exit.
- Timeout:
  - Counter clears on every state change.
  - Counts in INIT..LOAD only when the state's done condition is false. The switch-level qualifiers in LOAD do not count as waiting.
  - At all-ones → FAULT; fault_code = state code at timeout.
- Simultaneous events:
  - Done flag and timeout in the same cycle: the done flag wins.
  - sw_ena_rise in IDLE without arm_ok is ignored and not remembered.
- All outputs are registered; state-to-output latency is 1 cycle.

Optional Feature:
- CTRL_TIMEOUT_EN defined: timeout counter, FAULT state, fault and fault_code present as described.
- Not defined: no counter logic, FAULT unreachable, fault=0 and fault_code=0 constant, prog_led never 11.

Decomposition:
- Package ctrl_seq_pkg holds:
  - state localparams (RST..FAULT, 4-bit);
  - prog_led codes (LED_OFF, LED_BLINK, LED_ON, LED_FAULT);
  - N_CH upper bound constant.
- Sub-module ch_stagger: one instance per channel. Inputs: prev-enable-aged flag, ready, go. Output: enable. Internal STAGGER counter driving its own aged flag to the next channel.

Test Plan:
- Reset flow: sw_res=1, pulse sw_ena_rise → INIT; sub_reset high exactly 3 cycles; init_done, then cfg_done → controlstate 1→2→3, prog_led=01.
- Program/load: write_done → state 4 with prog_led=10; read_done, load_done, switches low → state 6.
- Stagger: N_CH=2, STAGGER=16, ch_ready=2'b11, sw_ena_rise with arm_ok → ch_en[0] at entry+16, ch_en[1] at entry+32. Repeat with ch_ready[1]=0 until entry+40 → ch_en[1] at entry+40.
- Exit: sw_ena low in ACTIVE → ch_en=0 same cycle, state 4.
- Timeout (CTRL_TIMEOUT_EN, TO_W=4): hold cfg_done=0 in state 2 → FAULT after 15 cycles, fault_code=2, ch_en=0; sw_res_rise → state 0, fault=0.
- Priority: sw_res_rise coincident with write_done in PROG → state 0, not 4. Async reset mid-ACTIVE → all outputs 0 immediately.
